// File: rtl/wr_port_arbiter_if.sv
// wr_port_arbiter_if
//   Requester-side request bundle plus the single-port write bus driven by
//   wr_port_arbiter.
//   master : the arbiter (consumes req/req_addr/req_data, drives gnt/busy/bus/err)
//   slave  : the requesting agents / bench (drives requests, observes the rest)
//   req       NUM_REQ         per-requester request
//   req_addr  NUM_REQ x ADDR_W per-requester beat address
//   req_data  NUM_REQ x DATA_W per-requester beat data
//   gnt       NUM_REQ         one-hot-or-zero grant
//   busy                      arbiter is serving a grant
//   ce/wr/addr/data           registered write bus
//   err/err_id                dropped-beat pulse and culprit index
interface wr_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             gnt;
  logic                           busy;
  logic                           ce;
  logic                           wr;
  logic [ADDR_W-1:0]              addr;
  logic [DATA_W-1:0]              data;
  logic                           err;
  logic [IDW-1:0]                 err_id;

  modport master (
    input  req, req_addr, req_data,
    output gnt, busy, ce, wr, addr, data, err, err_id
  );

  modport slave (
    output req, req_addr, req_data,
    input  gnt, busy, ce, wr, addr, data, err, err_id
  );
endinterface

// File: rtl/wr_port_arbiter.sv
// wr_port_arbiter
//   Round-robin arbiter and burst sequencer for a shared single-port write bus.
//   A requester seen in IDLE is granted one edge later; while it holds req,
//   each cycle is a beat, up to MAX_BURST beats per grant. Each beat is
//   window-checked against [ADDR_MIN, ADDR_MAX]: legal beats are written to
//   the bus one edge later, illegal ones are dropped with an err pulse.
//   Ports:
//     i_clk    clock, rising edge
//     i_rst_n  synchronous active-low reset
//     bus      wr_port_arbiter_if.master (requests in, grant/bus/err out)
//   Optional build macro: WR_ARB_ASSERT_EN compiles in embedded SVA checks
//   and cover points; behaviour is identical without it.

// Per-requester address window check.
module wr_port_arbiter_rchk #(
  parameter int ADDR_W   = 8,
  parameter int ADDR_MIN = 0,
  parameter int ADDR_MAX = 255
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_ok
);
  // Compare as signed ints so a zero lower bound is not a constant test.
  int w_a;
  always_comb begin
    w_a  = int'(i_addr);
    o_ok = (w_a >= ADDR_MIN) && (w_a <= ADDR_MAX);
  end
endmodule

module wr_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int ADDR_MIN  = 0,
  parameter int ADDR_MAX  = 255,
  parameter int MAX_BURST = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  wr_port_arbiter_if.master     bus
);
  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(MAX_BURST + 1);
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(MAX_BURST - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t              r_state;
  logic [IDW-1:0]      r_rr_ptr;
  logic [IDW-1:0]      r_owner;
  logic [CNTW-1:0]     r_beat_cnt;
  logic [NUM_REQ-1:0]  r_gnt;
  logic                r_ce;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_err;
  logic [IDW-1:0]      r_err_id;

  logic [NUM_REQ-1:0]  w_ok;
  logic [IDW-1:0]      w_sel;
  logic [IDW-1:0]      w_owner_nxt;
  logic                w_any;
  logic                w_beat;
  logic                w_last;
  int                  w_idx;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_lane
      wr_port_arbiter_rchk #(
        .ADDR_W   (ADDR_W),
        .ADDR_MIN (ADDR_MIN),
        .ADDR_MAX (ADDR_MAX)
      ) u_rchk (
        .i_addr (bus.req_addr[g]),
        .o_ok   (w_ok[g])
      );
    end
  endgenerate

  // First requester at or after r_rr_ptr. Scanning from the far end lets the
  // closest candidate overwrite the others.
  always_comb begin
    w_sel = r_rr_ptr;
    w_any = 1'b0;
    w_idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (bus.req[w_idx]) begin
        w_sel = IDW'(w_idx);
        w_any = 1'b1;
      end
    end
  end

  assign w_owner_nxt = (r_owner == IDW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_beat      = (r_state == S_GRANT) && bus.req[r_owner];
  assign w_last      = (r_beat_cnt == LAST_BEAT);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
      r_gnt      <= '0;
      r_ce       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_err      <= 1'b0;
      r_err_id   <= '0;
    end else begin
      // Bus outputs are single-cycle; only a beat this cycle sets them.
      r_ce     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
      r_err_id <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state    <= S_GRANT;
            r_owner    <= w_sel;
            r_gnt      <= NUM_REQ'(1) << w_sel;
            r_beat_cnt <= '0;
          end
        end
        S_GRANT: begin
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_ok[r_owner]) begin
              r_ce   <= 1'b1;
              r_addr <= bus.req_addr[r_owner];
              r_data <= bus.req_data[r_owner];
            end else begin
              r_err    <= 1'b1;
              r_err_id <= r_owner;
            end
          end
          // Release on req drop or on the final beat; dropped beats count too.
          if (!w_beat || w_last) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_rr_ptr <= w_owner_nxt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.busy   = (r_state == S_GRANT);
  assign bus.ce     = r_ce;
  assign bus.wr     = r_ce;
  assign bus.addr   = r_addr;
  assign bus.data   = r_data;
  assign bus.err    = r_err;
  assign bus.err_id = r_err_id;

`ifdef WR_ARB_ASSERT_EN
  // Consecutive cycles each grant line has already been high.
  logic [NUM_REQ-1:0][CNTW-1:0] r_gnt_run;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_gnt_run <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!bus.gnt[i])
          r_gnt_run[i] <= '0;
        else if (int'(r_gnt_run[i]) < MAX_BURST)
          r_gnt_run[i] <= r_gnt_run[i] + 1'b1;
      end
    end
  end

  a_gnt_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(bus.gnt));
  a_ce_wr: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    bus.ce |-> bus.wr);
  a_ce_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    bus.ce |-> (int'(bus.addr) >= ADDR_MIN && int'(bus.addr) <= ADDR_MAX));
  a_sole_req: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (r_state == S_IDLE && $onehot(bus.req)) |=> (bus.gnt == $past(bus.req)));
  c_full_burst: cover property (@(posedge i_clk) disable iff (!i_rst_n)
    w_beat && w_last);
  c_err: cover property (@(posedge i_clk) disable iff (!i_rst_n) bus.err);

  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_sva
      a_burst_len: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        bus.gnt[g] |-> (int'(r_gnt_run[g]) < MAX_BURST));
      c_gnt: cover property (@(posedge i_clk) disable iff (!i_rst_n) bus.gnt[g]);
    end
  endgenerate
`else
`endif

endmodule

// File: tb/tb_wr_port_arbiter.sv
// tb_wr_port_arbiter
//   Directed scenarios plus a randomized run checked against a cycle-level
//   behavioural model of the arbitration rules (owner index, beats done,
//   round-robin pointer as plain ints).
module tb_wr_port_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int ADDR_MIN  = 1;
  localparam int ADDR_MAX  = 5;
  localparam int MAX_BURST = 4;
  localparam int IDW       = $clog2(NUM_REQ);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wr_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  wr_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .ADDR_MIN(ADDR_MIN), .ADDR_MAX(ADDR_MAX), .MAX_BURST(MAX_BURST)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.master)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int m_owner = -1;
  int m_beats = 0;
  int m_rr    = 0;
  logic [NUM_REQ-1:0] e_gnt    = '0;
  logic               e_busy   = 1'b0;
  logic               e_ce     = 1'b0;
  logic [ADDR_W-1:0]  e_addr   = '0;
  logic [DATA_W-1:0]  e_data   = '0;
  logic               e_err    = 1'b0;
  logic [IDW-1:0]     e_err_id = '0;

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_edge();
    int a;
    e_ce = 0; e_addr = '0; e_data = '0; e_err = 0; e_err_id = '0;
    if (!rst_n) begin
      m_owner = -1; m_beats = 0; m_rr = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (m_owner < 0 && bus.req[(m_rr + k) % NUM_REQ]) begin
          m_owner = (m_rr + k) % NUM_REQ;
          m_beats = 0;
        end
      end
    end else if (bus.req[m_owner]) begin
      a = int'(bus.req_addr[m_owner]);
      if (a >= ADDR_MIN && a <= ADDR_MAX) begin
        e_ce = 1; e_addr = bus.req_addr[m_owner]; e_data = bus.req_data[m_owner];
      end else begin
        e_err = 1; e_err_id = IDW'(m_owner);
      end
      m_beats++;
      if (m_beats == MAX_BURST) begin
        m_rr = (m_owner + 1) % NUM_REQ; m_owner = -1;
      end
    end else begin
      m_rr = (m_owner + 1) % NUM_REQ; m_owner = -1;
    end
    e_gnt  = '0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    e_busy = (m_owner >= 0);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; bus.req = '0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    bus.req = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_addr[i] = 8'd2; bus.req_data[i] = 8'h55;
    end
    rst_n = 0;
    tick(); tick();
    n_chk++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", bus.gnt); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_chk++; if ({bus.ce, bus.wr} !== 2'b00) begin n_fail++; $display("FAIL reset_ce_wr: got %b%b want 00", bus.ce, bus.wr); end
    n_chk++; if ({bus.addr, bus.data} !== '0) begin n_fail++; $display("FAIL reset_addr_data: got %h/%h want 0/0", bus.addr, bus.data); end
    n_chk++; if ({bus.err, bus.err_id} !== '0) begin n_fail++; $display("FAIL reset_err: got %b/%0d want 0/0", bus.err, bus.err_id); end
    rst_n = 1; bus.req = '0;
  endtask

  task automatic test_single_burst();
    do_reset();
    bus.req = 4'b0001; bus.req_addr[0] = 8'd1; bus.req_data[0] = 8'hA0;
    tick();
    n_chk++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", bus.gnt); end
    for (int b = 0; b < 4; b++) begin
      bus.req_addr[0] = ADDR_W'(b + 1); bus.req_data[0] = DATA_W'(8'hA0 + b);
      tick();
      n_chk++;
      if (bus.ce !== 1'b1 || bus.wr !== 1'b1 || bus.addr !== ADDR_W'(b + 1) || bus.data !== DATA_W'(8'hA0 + b)) begin
        n_fail++; $display("FAIL single_beat%0d: got ce=%b wr=%b addr=%0d data=%h want 1 1 %0d %h",
                           b, bus.ce, bus.wr, bus.addr, bus.data, b + 1, 8'hA0 + b);
      end
      n_chk++;
      if (bus.gnt !== ((b < 3) ? 4'b0001 : 4'b0000)) begin
        n_fail++; $display("FAIL single_gnt%0d: got %b want %b", b, bus.gnt, (b < 3) ? 4'b0001 : 4'b0000);
      end
    end
    bus.req = '0;
    tick();
    n_chk++; if (bus.ce !== 1'b0) begin n_fail++; $display("FAIL single_idle_ce: got %b want 0", bus.ce); end
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] eg;
    logic ec;
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_addr[i] = 8'd2; bus.req_data[i] = DATA_W'(i);
    end
    for (int c = 1; c <= 24; c++) begin
      tick();
      eg = '0;
      if (c % 5 != 0) eg[((c - 1) / 5) % 4] = 1'b1;
      ec = (c >= 2) && ((c - 1) % 5 != 0);
      n_chk++; if (bus.gnt !== eg) begin n_fail++; $display("FAIL rr_gnt c%0d: got %b want %b", c, bus.gnt, eg); end
      n_chk++; if (bus.ce !== ec) begin n_fail++; $display("FAIL rr_ce c%0d: got %b want %b", c, bus.ce, ec); end
    end
    bus.req = '0;
  endtask

  task automatic test_early_release();
    int writes = 0;
    do_reset();
    bus.req = 4'b0100; bus.req_addr[2] = 8'd3; bus.req_data[2] = 8'h33;
    tick();
    n_chk++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL early_grant: got %b want 0100", bus.gnt); end
    tick(); if (bus.ce) writes++;
    tick(); if (bus.ce) writes++;
    bus.req = '0;
    tick(); if (bus.ce) writes++;
    n_chk++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL early_gnt_fall: got %b want 0000", bus.gnt); end
    n_chk++; if (writes !== 2) begin n_fail++; $display("FAIL early_writes: got %0d want 2", writes); end
    bus.req = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) bus.req_addr[i] = 8'd4;
    tick();
    n_chk++; if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL early_rr_ptr: got %b want 1000", bus.gnt); end
    bus.req = '0;
  endtask

  task automatic test_range_error();
    int writes = 0;
    do_reset();
    bus.req = 4'b0010; bus.req_addr[1] = 8'd6; bus.req_data[1] = 8'h66;
    tick();
    n_chk++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL err_grant: got %b want 0010", bus.gnt); end
    tick();
    n_chk++;
    if (bus.ce !== 1'b0 || bus.err !== 1'b1 || bus.err_id !== IDW'(1) || bus.addr !== '0) begin
      n_fail++; $display("FAIL err_pulse: got ce=%b err=%b id=%0d addr=%0d want 0 1 1 0", bus.ce, bus.err, bus.err_id, bus.addr);
    end
    for (int b = 0; b < 3; b++) begin
      bus.req_addr[1] = ADDR_W'(2 + b);
      tick();
      if (bus.ce) writes++;
      n_chk++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_clear%0d: got %b want 0", b, bus.err); end
    end
    n_chk++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL err_burst_end: got %b want 0000", bus.gnt); end
    tick();
    if (bus.ce) writes++;
    n_chk++; if (writes !== 3) begin n_fail++; $display("FAIL err_writes: got %0d want 3", writes); end
    bus.req = '0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.req = 4'b0100; bus.req_addr[2] = 8'd3; bus.req_data[2] = 8'h77;
    tick(); tick();
    n_chk++; if (bus.ce !== 1'b1) begin n_fail++; $display("FAIL mid_first_beat: got ce=%b want 1", bus.ce); end
    rst_n = 0;
    tick();
    n_chk++;
    if (bus.gnt !== '0 || bus.ce !== 1'b0 || bus.busy !== 1'b0 || bus.addr !== '0) begin
      n_fail++; $display("FAIL mid_reset: got gnt=%b ce=%b busy=%b addr=%0d want 0 0 0 0", bus.gnt, bus.ce, bus.busy, bus.addr);
    end
    rst_n = 1; bus.req = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) bus.req_addr[i] = 8'd2;
    tick();
    n_chk++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_regrant: got %b want 0001", bus.gnt); end
    bus.req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(0, 3) == 0) bus.req[i] = ~bus.req[i];
        bus.req_addr[i] = ADDR_W'($urandom_range(0, 7));
        bus.req_data[i] = DATA_W'($urandom);
      end
      tick();
      n_chk++; if (bus.gnt !== e_gnt) begin n_fail++; $display("FAIL rand_gnt c%0d: got %b want %b", c, bus.gnt, e_gnt); end
      n_chk++; if (bus.busy !== e_busy) begin n_fail++; $display("FAIL rand_busy c%0d: got %b want %b", c, bus.busy, e_busy); end
      n_chk++;
      if ({bus.ce, bus.wr, bus.addr, bus.data} !== {e_ce, e_ce, e_addr, e_data}) begin
        n_fail++; $display("FAIL rand_bus c%0d: got ce=%b wr=%b a=%0d d=%h want %b %b %0d %h",
                           c, bus.ce, bus.wr, bus.addr, bus.data, e_ce, e_ce, e_addr, e_data);
      end
      n_chk++; if (bus.err !== e_err) begin n_fail++; $display("FAIL rand_err c%0d: got %b want %b", c, bus.err, e_err); end
      if (e_err) begin
        n_chk++; if (bus.err_id !== e_err_id) begin n_fail++; $display("FAIL rand_err_id c%0d: got %0d want %0d", c, bus.err_id, e_err_id); end
      end
    end
    rst_n = 1; bus.req = '0;
  endtask

  initial begin
    bus.req = '0; bus.req_addr = '0; bus.req_data = '0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_early_release();
    test_range_error();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wr_port_arbiter.md
# wr_port_arbiter

Round-robin arbiter and sequencer for the shared single-port write bus (`ce`, `wr`, `addr`, `data`). Up to NUM_REQ requesters raise `req` and are granted the bus with a one-cycle request-to-grant latency (req |=> gnt). Each requester may issue a bounded burst of write beats, and each beat is address-window-checked before it reaches the bus. The block sits between the requesting agents and the memory/register target, and it is the only driver of the write bus.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- ADDR_W, 8: address width
- DATA_W, 8: data width
- ADDR_MIN, 0: lowest legal write address (inclusive, unsigned)
- ADDR_MAX, 255: highest legal write address (inclusive, unsigned)
- MAX_BURST, 4: maximum beats per grant (1..16)
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  reset; synchronous and active-low
- req  in  NUM_REQ  per-requester request, held high while beats remain
- req_addr  in  NUM_REQ*ADDR_W  per-requester beat address; slice i belongs to requester i
- req_data  in  NUM_REQ*DATA_W  per-requester beat data
- gnt  out  NUM_REQ  one-hot-or-zero grant
- busy  out  1  FSM is not IDLE
- ce  out  1  bus chip enable (registered)
- wr  out  1  bus write strobe (registered, always equal to ce)
- addr  out  ADDR_W  bus address (registered)
- data  out  DATA_W  bus data (registered)
- err  out  1  one-cycle pulse: a beat was dropped as out of range
- err_id  out  $clog2(NUM_REQ)  index of the requester that caused `err`

## Operation
- FSM has two states: IDLE and GRANT.
- IDLE: if any `req` is high, select the first requester at or after `rr_ptr` (wrapping modulo NUM_REQ). At the next edge: `gnt[sel]` goes to 1, the FSM enters GRANT, and `beat_cnt` is cleared to 0. If no `req` is high, the FSM stays in IDLE.
- GRANT, owner i: every cycle where `gnt[i] && req[i]` is a beat, and `beat_cnt` increments by 1.
- Per beat, when `req_addr[i]` is in [ADDR_MIN, ADDR_MAX]: on the next edge `ce=wr=1`, `addr=req_addr[i]`, `data=req_data[i]`.
- Per beat, when the address is out of range: on the next edge `ce=wr=0`, `addr=data=0`, `err=1`, `err_id=i`. A dropped beat still counts toward MAX_BURST.
- In any cycle with no beat: `ce=wr=err=0` and `addr=data=0`.
- Leave GRANT for IDLE, with `gnt` forced to 0 at the next edge, when either condition holds:
  - `req[i]` is low; no beat is issued in that cycle.
  - A beat is issued with `beat_cnt == MAX_BURST-1`.
- On leaving GRANT, `rr_ptr` is set to (i+1) mod NUM_REQ.
- A granted requester never loses the bus to a higher-priority requester mid-burst; there is no preemption.
- `busy` is 1 exactly when the FSM is in GRANT.
- Requests that arrive while the bus is in GRANT are held off. They are considered at the next IDLE arbitration.

## Timing
- Reset (`rst_n` low at an edge):
  - At the same edge: FSM goes to IDLE, `rr_ptr=0`, `beat_cnt=0`.
  - All outputs go to 0: `gnt`, `busy`, `ce`, `wr`, `addr`, `data`, `err`, `err_id`.
  - This applies mid-burst. Any in-flight beat is discarded and never appears on the bus.
- Grant latency: `req` high in IDLE at edge t gives `gnt` high from edge t+1.
- Write latency: a beat sampled at edge t appears on the bus from edge t+1, for one cycle.
- Burst timing with `req` held: `gnt` is high for exactly MAX_BURST cycles and drops for at least one cycle. The earliest next grant is MAX_BURST+2 cycles after the request.
- Minimum grant gap is one cycle in every case; at least one IDLE cycle always separates grants.
- Simultaneous `req` at IDLE: the round-robin order from `rr_ptr` decides.
- Wrap-around: after requester NUM_REQ-1 is served, `rr_ptr` returns to 0.
- Boundary addresses ADDR_MIN and ADDR_MAX are legal. ADDR_MIN-1 and ADDR_MAX+1 are errors.

## Configuration
- WR_ARB_ASSERT_EN: compiles in embedded concurrent SVA, clocked on `posedge clk` and disabled while `!rst_n`. The checks are:
  - `$onehot0(gnt)`.
  - `ce |-> wr`.
  - `ce |-> addr >= ADDR_MIN && addr <= ADDR_MAX`.
  - A sole `req` in IDLE gives `|=> gnt` for that requester.
  - `gnt[i]` is never high for more than MAX_BURST consecutive cycles.
  - Cover points: a full MAX_BURST burst, an `err` pulse, and a grant to every requester.
- Without the macro, no assertion or cover code is present. Functional behaviour is identical in both builds.

## Test plan
- Single requester, range-limited burst: ADDR_MIN=1, ADDR_MAX=5, MAX_BURST=4. `req[0]` is held with addresses 1,2,3,4.
  - Required: `gnt[0]` high for 4 cycles starting 1 cycle after `req`.
  - Required: ce=1 with addr 1,2,3,4, each one cycle after its beat.
  - Required: `gnt[0]` low in the 5th cycle.
- Round robin: `req[3:0]=4'b1111` held continuously.
  - Required: grant order 0,1,2,3,0.
  - Required: each grant lasts 4 cycles, separated by exactly 1 idle cycle.
- Early release: `req[2]` high for 2 beats, then low.
  - Required: exactly 2 bus writes.
  - Required: `gnt[2]` falls the cycle after `req[2]` falls.
  - Required: `rr_ptr` advances to 3.
- Range error: a beat from requester 1 with addr=6 (ADDR_MAX=5).
  - Required: ce=0, err=1, err_id=1 for one cycle.
  - Required: the beat counts, so only 3 further beats are issued in that burst.
- Reset mid-burst: `rst_n` low during the 2nd beat of a grant.
  - Required: next edge gives gnt=0, ce=0, busy=0.
  - Required: after release, with all `req` high, requester 0 is granted first.
